// File: rtl/regfile_seq.sv
// Command sequencer for an 8-entry register file: reads operands, runs MOVI/ADD/AND/MVN,
// writes the result back, and reports result and {V,N,Z} status.
module regfile_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [2:0]   cmd_rd,
  input  logic [2:0]   cmd_rn,
  input  logic [2:0]   cmd_rm,
  input  logic [W-1:0] cmd_imm,
  output logic [2:0]   rf_readnum,
  input  logic [W-1:0] rf_data_out,
  output logic [2:0]   rf_writenum,
  output logic         rf_write,
  output logic [W-1:0] rf_data_in,
  output logic         done,
  output logic [W-1:0] result,
  output logic [2:0]   status
);
  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     op_q;
  logic [2:0]     rd_q, rn_q, rm_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   alu_res;
  logic           alu_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) begin
        case (cmd_op)
          OP_MOVI: state_nxt = WB;
          OP_MVN:  state_nxt = RDB;
          default: state_nxt = RDA;
        endcase
      end
      RDA:     state_nxt = RDB;
      RDB:     state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore strobes; an async reset to IDLE drops rf_write immediately
  always_comb begin
    cmd_ready  = (state == IDLE);
    rf_write   = (state == WB);
    done       = (state == DONE);
    rf_readnum = 3'd0;
    if (state == RDA) rf_readnum = rn_q;
    if (state == RDB) rf_readnum = rm_q;
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_MVN:  alu_res = ~b_q;
      default: alu_res = '0;
    endcase
    alu_v = (op_q == OP_ADD) && (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
  end

  // Write port registers load on entry to WB and hold between commands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      status      <= '0;
      rf_writenum <= '0;
      rf_data_in  <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op_q <= cmd_op;
          rd_q <= cmd_rd;
          rn_q <= cmd_rn;
          rm_q <= cmd_rm;
          if (cmd_op == OP_MOVI) begin
            result      <= cmd_imm;
            rf_data_in  <= cmd_imm;
            rf_writenum <= cmd_rd;
          end
        end
        RDA:  a_q <= rf_data_out;
        RDB:  b_q <= rf_data_out;
        EXEC: begin
          result      <= alu_res;
          status      <= {alu_v, alu_res[W-1], (alu_res == '0)};
          rf_data_in  <= alu_res;
          rf_writenum <= rd_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq: behavioural register file, reference model at accept,
// write/done checks popped from a queue as the sequencer produces them.
module tb_regfile_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [2:0]   cmd_rd, cmd_rn, cmd_rm;
  logic [W-1:0] cmd_imm;
  logic [2:0]   rf_readnum;
  logic [W-1:0] rf_data_out;
  logic [2:0]   rf_writenum;
  logic         rf_write;
  logic [W-1:0] rf_data_in;
  logic         done;
  logic [W-1:0] result;
  logic [2:0]   status;

  regfile_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_imm(cmd_imm),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_data_in(rf_data_in), .done(done), .result(result), .status(status)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, clocked write
  logic [W-1:0] rf_mem [8] = '{default: '0};
  assign rf_data_out = rf_mem[rf_readnum];
  always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;

  typedef struct {
    logic [1:0]   op;
    logic [2:0]   rd, rn, rm;
    logic [W-1:0] data;
    logic [2:0]   st;
    int           lat;
    time          acc;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] ref_mem [8];
  logic [2:0]   ref_st;
  int           passed = 0;
  int           total  = 0;
  int           done_cnt = 0;
  int           issued = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Drive a command (valid stays high afterwards) and log expectations on accept
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [W-1:0] imm);
    exp_t e;
    logic [W-1:0] a, b, r;
    bit ok = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    a = ref_mem[rn]; b = ref_mem[rm];
    case (op)
      2'b00: r = imm;
      2'b01: r = a + b;
      2'b10: r = a & b;
      default: r = ~b;
    endcase
    if (op != 2'b00)
      ref_st = {(op == 2'b01) && (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]), r[W-1], r == '0};
    ref_mem[rd] = r;
    e.op = op; e.rd = rd; e.rn = rn; e.rm = rm; e.data = r; e.st = ref_st;
    e.lat = (op == 2'b00) ? 2 : (op == 2'b11) ? 4 : 5;
    e.acc = $time;
    q.push_back(e);
    issued++;
  endtask

  always @(negedge clk) begin
    int k;
    if (!reset) begin
      if (q.size() > 0) begin
        k = int'(($time - q[0].acc + 5) / 10);
        if ((q[0].op == 2'b01 || q[0].op == 2'b10) && k == 1) chk("readnum_a", rf_readnum, q[0].rn);
        if ((q[0].op == 2'b01 || q[0].op == 2'b10) && k == 2) chk("readnum_b", rf_readnum, q[0].rm);
        if (q[0].op == 2'b11 && k == 1) chk("readnum_mvn", rf_readnum, q[0].rm);
      end
      if (rf_write) begin
        if (q.size() == 0) chk("wr_spurious", 1, 0);
        else begin
          chk("wr_num", rf_writenum, q[0].rd);
          chk("wr_data", rf_data_in, q[0].data);
        end
      end
      if (done) begin
        done_cnt++;
        if (q.size() == 0) chk("done_spurious", 1, 0);
        else begin
          k = int'(($time - q[0].acc + 5) / 10);
          chk("latency", k, q[0].lat);
          chk("result", result, q[0].data);
          chk("status", status, q[0].st);
          chk("regfile", rf_mem[q[0].rd], q[0].data);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int d0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    ref_st = '0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_write", rf_write, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_status", status, 0);
    chk("rst_readnum", rf_readnum, 0);
    chk("rst_writenum", rf_writenum, 0);
    chk("rst_data_in", rf_data_in, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset mid-RDB aborts an ADD with no write and no done
    issue(2'b01, 3'd6, 3'd1, 3'd2, '0);
    @(negedge clk) cmd_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    d0 = done_cnt;
    chk("abort_ready", cmd_ready, 1);
    chk("abort_write", rf_write, 0);
    chk("abort_result", result, 0);
    chk("abort_status", status, 0);
    q.delete();
    issued--;
    ref_st = '0;
    ref_mem[6] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_write", rf_mem[6], 0);
    d0 = done_cnt;
    issued = 0;

    // Directed sequence with cmd_valid held high throughout
    issue(2'b00, 3'd3, 3'd0, 3'd0, 16'h0042);
    issue(2'b00, 3'd1, 3'd0, 3'd0, 16'h7FFF);
    issue(2'b00, 3'd2, 3'd0, 3'd0, 16'h0001);
    issue(2'b01, 3'd0, 3'd1, 3'd2, '0);
    issue(2'b00, 3'd4, 3'd0, 3'd0, 16'h00F0);
    issue(2'b00, 3'd5, 3'd0, 3'd0, 16'h0F00);
    issue(2'b10, 3'd4, 3'd4, 3'd5, '0);
    issue(2'b01, 3'd6, 3'd4, 3'd3, '0);
    issue(2'b00, 3'd7, 3'd0, 3'd0, 16'hFFFF);
    issue(2'b11, 3'd7, 3'd0, 3'd7, '0);
    for (int i = 0; i < 12; i++)
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 16'($urandom));
    @(negedge clk) cmd_valid = 1'b0;

    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    chk("done_count", done_cnt - d0, issued);
    chk("final_r0", rf_mem[0], ref_mem[0]);
    chk("final_r7", rf_mem[7], ref_mem[7]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
